// File: rtl/nibble_assembler.sv
// nibble_assembler: packs nibble pairs into bytes with valid/ready handshakes and a delivery count; NIBBLE_ASM_FLUSH_EN adds a flush port
module nibble_assembler (
    input  logic        clk,
    input  logic        rst,
`ifdef NIBBLE_ASM_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        swap,
    input  logic        nib_valid,
    input  logic [3:0]  nib_in,
    output logic        nib_ready,
    output logic        byte_valid,
    output logic [7:0]  byte_out,
    input  logic        byte_ready,
    output logic [15:0] byte_cnt
);
    typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;
    state_t state;
    logic [3:0] held;
    logic [3:0] second;
    logic order;
    logic accept;
    logic close;
    assign nib_ready = (state == FULL) ? byte_ready : 1'b1;
    assign accept = nib_valid && nib_ready;
`ifdef NIBBLE_ASM_FLUSH_EN
    assign close = accept || flush;
`else
    assign close = accept;
`endif
    // a flushed byte completes with a zero second nibble
    assign second = accept ? nib_in : 4'h0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            held       <= 4'h0;
            order      <= 1'b0;
            byte_valid <= 1'b0;
            byte_out   <= 8'h00;
            byte_cnt   <= 16'h0000;
        end else begin
            if (byte_valid && byte_ready)
                byte_cnt <= byte_cnt + 16'd1;
            case (state)
                EMPTY: if (accept) begin
                    held  <= nib_in;
                    order <= swap;
                    state <= HALF;
                end
                HALF: if (close) begin
                    byte_out   <= order ? {second, held} : {held, second};
                    byte_valid <= 1'b1;
                    state      <= FULL;
                end
                FULL: if (byte_ready) begin
                    byte_valid <= 1'b0;
                    state      <= accept ? HALF : EMPTY;
                    if (accept) begin
                        held  <= nib_in;
                        order <= swap;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_assembler.sv
// tb_nibble_assembler: directed checks of nibble_assembler; define NIBBLE_ASM_FLUSH_EN to exercise flush
module tb_nibble_assembler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        swap = 1'b0;
    logic        nib_valid = 1'b0;
    logic [3:0]  nib_in = 4'h0;
    logic        nib_ready;
    logic        byte_valid;
    logic [7:0]  byte_out;
    logic        byte_ready = 1'b0;
    logic [15:0] byte_cnt;
    int n_cmp = 0;
    int n_err = 0;

    nibble_assembler dut (
        .clk(clk),
        .rst(rst),
`ifdef NIBBLE_ASM_FLUSH_EN
        .flush(flush),
`endif
        .swap(swap),
        .nib_valid(nib_valid),
        .nib_in(nib_in),
        .nib_ready(nib_ready),
        .byte_valid(byte_valid),
        .byte_out(byte_out),
        .byte_ready(byte_ready),
        .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] n, input logic s);
        nib_valid = 1'b1;
        nib_in = n;
        swap = s;
        tick;
        nib_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] a;
        logic [3:0] b;
        tick;
        tick;
        rst = 1'b0;
        #1;
        check("rst_valid", 16'(byte_valid), 16'h0);
        check("rst_out", 16'(byte_out), 16'h00);
        check("rst_cnt", byte_cnt, 16'h0);
        check("rst_ready", 16'(nib_ready), 16'h1);
        byte_ready = 1'b1;
        send(4'hA, 1'b0);
        check("half_valid", 16'(byte_valid), 16'h0);
        send(4'h5, 1'b0);
        check("a5_valid", 16'(byte_valid), 16'h1);
        check("a5_out", 16'(byte_out), 16'hA5);
        check("a5_cnt_pre", byte_cnt, 16'h0);
        tick;
        check("a5_valid_drop", 16'(byte_valid), 16'h0);
        check("a5_out_kept", 16'(byte_out), 16'hA5);
        check("a5_cnt", byte_cnt, 16'h1);
        send(4'hA, 1'b1);
        send(4'h5, 1'b1);
        check("swap_out", 16'(byte_out), 16'h5A);
        tick;
        send(4'hA, 1'b1);
        send(4'h5, 1'b0);
        check("swap_toggle_out", 16'(byte_out), 16'h5A);
        tick;
        check("cnt3", byte_cnt, 16'h3);
        byte_ready = 1'b0;
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        nib_valid = 1'b1;
        nib_in = 4'h9;
        swap = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_ready", 16'(nib_ready), 16'h0);
            check("stall_valid", 16'(byte_valid), 16'h1);
            check("stall_out", 16'(byte_out), 16'h12);
            tick;
        end
        check("stall_cnt", byte_cnt, 16'h3);
        byte_ready = 1'b1;
        #1;
        check("release_ready", 16'(nib_ready), 16'h1);
        tick;
        check("release_valid", 16'(byte_valid), 16'h0);
        check("release_cnt", byte_cnt, 16'h4);
        send(4'h3, 1'b0);
        check("overlap_out", 16'(byte_out), 16'h93);
        check("overlap_valid", 16'(byte_valid), 16'h1);
        nib_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            nib_in = 4'(i);
            #1;
            check("stream_ready", 16'(nib_ready), 16'h1);
            tick;
            if (i % 2 == 1) begin
                a = 4'(i - 1);
                b = 4'(i);
                check("stream_out", 16'(byte_out), 16'({a, b}));
                check("stream_valid_hi", 16'(byte_valid), 16'h1);
            end else begin
                check("stream_valid_lo", 16'(byte_valid), 16'h0);
            end
        end
        nib_valid = 1'b0;
        tick;
        check("stream_cnt", byte_cnt, 16'h9);
        send(4'hF, 1'b0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        check("rsthalf_valid", 16'(byte_valid), 16'h0);
        check("rsthalf_out", 16'(byte_out), 16'h00);
        check("rsthalf_cnt", byte_cnt, 16'h0);
        check("rsthalf_ready", 16'(nib_ready), 16'h1);
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        check("rsthalf_byte", 16'(byte_out), 16'h12);
        tick;
        check("rsthalf_cnt1", byte_cnt, 16'h1);
        byte_ready = 1'b0;
        send(4'h4, 1'b1);
        send(4'h4, 1'b0);
        nib_valid = 1'b1;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        nib_valid = 1'b0;
        #1;
        check("rstfull_valid", 16'(byte_valid), 16'h0);
        check("rstfull_cnt", byte_cnt, 16'h0);
        check("rstfull_ready", 16'(nib_ready), 16'h1);
        byte_ready = 1'b1;
        force dut.byte_cnt = 16'hFFFE;
        #1;
        release dut.byte_cnt;
        send(4'h1, 1'b0);
        send(4'h1, 1'b0);
        tick;
        check("cnt_ffff", byte_cnt, 16'hFFFF);
        send(4'h2, 1'b0);
        send(4'h2, 1'b0);
        tick;
        check("cnt_wrap", byte_cnt, 16'h0000);
`ifdef NIBBLE_ASM_FLUSH_EN
        flush = 1'b1;
        tick;
        check("flush_empty", 16'(byte_valid), 16'h0);
        flush = 1'b0;
        send(4'h7, 1'b0);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("flush_out", 16'(byte_out), 16'h70);
        check("flush_valid", 16'(byte_valid), 16'h1);
        tick;
        send(4'h7, 1'b1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("flush_swap", 16'(byte_out), 16'h07);
        tick;
        send(4'h3, 1'b0);
        flush = 1'b1;
        send(4'h4, 1'b0);
        flush = 1'b0;
        check("flush_accept", 16'(byte_out), 16'h34);
        tick;
        check("flush_cnt", byte_cnt, 16'h3);
`else
        send(4'h7, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick;
            check("lone_hold", 16'(byte_valid), 16'h0);
        end
        send(4'h8, 1'b0);
        check("lone_out", 16'(byte_out), 16'h78);
        tick;
        check("lone_cnt", byte_cnt, 16'h1);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
